// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified memory bus arbiter: owner/state encodings
// and the bus access-size codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} ownerT;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arbStateT;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    // Instruction fetch is always a full word.
    localparam logic [2:0] SIZE_FETCH = SIZE_W;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus: the arbiter is the master, the memory is the slave.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arb_sel.sv
// Winner selection between fetch and data, with a starvation counter that
// forces a fetch grant after STARVE_LIMIT consecutive data grants.
module mem_arb_sel
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  if_req,
    input  logic  dm_req,
    input  logic  grant_en,
    input  ownerT exclude,
    output logic  grant_if,
    output logic  grant_dm
);
    logic [3:0] starveCnt;
    logic       ifCand, dmCand, starved;

    always_comb begin
        ifCand   = grant_en && if_req && (exclude != OWN_IF);
        dmCand   = grant_en && dm_req && (exclude != OWN_DM);
        starved  = (starveCnt == 4'(STARVE_LIMIT));
        grant_if = ifCand && (!dmCand || starved);
        grant_dm = dmCand && !(ifCand && starved);
    end

    // Counts data grants taken while fetch waits; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset || !if_req || grant_if)
            starveCnt <= '0;
        else if (grant_dm && !starved)
            starveCnt <= starveCnt + 4'd1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between fetch and data stages: latch winner, run the
// req/ready handshake, then pulse the winner's ack for one cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    mem_arbiter_if.master     mem,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);
    typedef struct packed {
        logic              we;
        logic [2:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } busReqT;

    arbStateT state, nextState;
    ownerT    owner, exclude;
    busReqT   busReg, ifPkt, dmPkt;
    logic     grantIf, grantDm, grantEn;
    logic [DATA_W-1:0] ifRdataR, dmRdataR;

    assign grantEn = (state == ARB_IDLE) || (state == ARB_RESP);
    // The requester being acked may still hold its old req this cycle.
    assign exclude = (state == ARB_RESP) ? owner : OWN_NONE;

    mem_arb_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .grant_en (grantEn),
        .exclude  (exclude),
        .grant_if (grantIf),
        .grant_dm (grantDm)
    );

    always_comb begin
        ifPkt = '{we: 1'b0, size: SIZE_FETCH, addr: if_addr, wdata: '0};
        dmPkt = '{we: dm_we, size: dm_size, addr: dm_addr, wdata: dm_wdata};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ARB_IDLE: if (grantIf || grantDm) nextState = ARB_BUSY;
            ARB_BUSY: if (mem.mem_ready)      nextState = ARB_RESP;
            ARB_RESP: nextState = (grantIf || grantDm) ? ARB_BUSY : ARB_IDLE;
            default:  nextState = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_NONE;
            busReg   <= '0;
            ifRdataR <= '0;
            dmRdataR <= '0;
        end else begin
            if (grantIf) begin
                busReg <= ifPkt;
                owner  <= OWN_IF;
            end else if (grantDm) begin
                busReg <= dmPkt;
                owner  <= OWN_DM;
            end else if (state == ARB_RESP) begin
                owner  <= OWN_NONE;
            end
            if (state == ARB_BUSY && mem.mem_ready) begin
                if (owner == OWN_IF)
                    ifRdataR <= mem.mem_rdata;
                else if (owner == OWN_DM)
                    dmRdataR <= busReg.we ? '0 : mem.mem_rdata;
            end
        end
    end

    assign mem.mem_req   = (state == ARB_BUSY);
    assign mem.mem_we    = busReg.we;
    assign mem.mem_size  = busReg.size;
    assign mem.mem_addr  = busReg.addr;
    assign mem.mem_wdata = busReg.wdata;

    assign if_ack    = (state == ARB_RESP) && (owner == OWN_IF);
    assign dm_ack    = (state == ARB_RESP) && (owner == OWN_DM);
    assign if_rdata  = ifRdataR;
    assign dm_rdata  = dmRdataR;
    assign stall_if  = if_req && !if_ack;
    assign stall_mem = dm_req && !dm_ack;
    assign busy      = (state == ARB_BUSY);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the selector is also driven standalone so
// the starvation limit can be reached.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk, reset;
    logic        if_req, if_ack, dm_req, dm_we, dm_ack;
    logic        stall_if, stall_mem, busy;
    logic [2:0]  dm_size;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;

    logic  selIf, selDm, selEn, selGif, selGdm;
    ownerT selEx;

    int checks = 0;
    int errors = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) memBus();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem(memBus), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    mem_arb_sel #(.STARVE_LIMIT(4)) selDut (
        .clk(clk), .reset(reset), .if_req(selIf), .dm_req(selDm),
        .grant_en(selEn), .exclude(selEx), .grant_if(selGif), .grant_dm(selGdm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A requester must hold req until its ack.
    assert property (@(posedge clk) (if_req && !if_ack && !reset) |=> (if_req || reset))
        else $error("if_req dropped before if_ack");
    assert property (@(posedge clk) (dm_req && !dm_ack && !reset) |=> (dm_req || reset))
        else $error("dm_req dropped before dm_ack");

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are checked on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starvation vectors for the standalone selector, one row per cycle.
    bit    vIf[19] = '{1,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1,1,1,1};
    bit    vDm[19] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    bit    vEn[19] = '{1,1,1,1,1,1,1,0,1,1,1,1,1,1,1,1,1,1,1};
    ownerT vEx[19] = '{OWN_NONE,OWN_NONE,OWN_NONE,OWN_NONE,OWN_NONE,OWN_NONE,OWN_DM,
                       OWN_NONE,OWN_NONE,OWN_NONE,OWN_NONE,OWN_NONE,OWN_NONE,OWN_NONE,
                       OWN_NONE,OWN_NONE,OWN_NONE,OWN_IF,OWN_NONE};
    bit    eIf[19] = '{0,0,0,0,1,0,1,0,0,0,0,0,0,0,0,0,1,0,1};
    bit    eDm[19] = '{1,1,1,1,0,1,0,0,1,1,1,1,1,1,1,1,0,1,0};

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
        dm_size = '0; dm_addr = '0; dm_wdata = '0;
        memBus.mem_ready = 0; memBus.mem_rdata = '0;
        selIf = 0; selDm = 0; selEn = 0; selEx = OWN_NONE;
        cyc(); cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_memreq", memBus.mem_req, 0);
        chk("rst_memaddr", {memBus.mem_we, memBus.mem_size, memBus.mem_addr, memBus.mem_wdata}, 0);
        chk("rst_acks", {if_ack, dm_ack, busy}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);

        // Fetch only: ack in the third cycle counting the request cycle.
        cyc(); if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        chk("f_idle_stall", {stall_if, busy, memBus.mem_req}, 3'b100);
        cyc(); memBus.mem_ready = 1; memBus.mem_rdata = 32'h00500093;
        @(negedge clk);
        chk("f_busy", {busy, memBus.mem_req, memBus.mem_we, if_ack}, 4'b1100);
        chk("f_addr", memBus.mem_addr, 32'h100);
        chk("f_size", memBus.mem_size, 3'd2);
        cyc(); memBus.mem_ready = 0;
        @(negedge clk);
        chk("f_ack", {if_ack, memBus.mem_req, stall_if}, 3'b100);
        chk("f_rdata", if_rdata, 32'h00500093);
        cyc(); if_req = 0;
        @(negedge clk);
        chk("f_done", {if_ack, busy}, 0);
        chk("f_hold", if_rdata, 32'h00500093);

        // Simultaneous: store first, then fetch straight from RESP.
        cyc(); if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 1; dm_size = SIZE_W;
        dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("s_stalls", {stall_if, stall_mem, busy}, 3'b110);
        cyc(); memBus.mem_ready = 1; memBus.mem_rdata = 32'h55;
        @(negedge clk);
        chk("s_st_we", {memBus.mem_req, memBus.mem_we}, 2'b11);
        chk("s_st_addr", memBus.mem_addr, 32'h2000);
        chk("s_st_wdata", memBus.mem_wdata, 32'hDEADBEEF);
        cyc(); memBus.mem_ready = 0;
        @(negedge clk);
        chk("s_dm_ack", {dm_ack, if_ack, stall_mem, stall_if}, 4'b1001);
        chk("s_st_rdata", dm_rdata, 0);
        cyc(); dm_req = 0; dm_we = 0; memBus.mem_ready = 1; memBus.mem_rdata = 32'h00A00113;
        @(negedge clk);
        chk("s_f_direct", {busy, memBus.mem_we, dm_ack}, 3'b100);
        chk("s_f_addr", memBus.mem_addr, 32'h104);
        cyc(); memBus.mem_ready = 0;
        @(negedge clk);
        chk("s_if_ack", if_ack, 1);
        chk("s_if_rdata", if_rdata, 32'h00A00113);
        cyc(); if_req = 0;
        @(negedge clk);
        chk("s_idle", {busy, if_ack}, 0);

        // Wait states; mem_ready in IDLE is ignored.
        cyc(); dm_req = 1; dm_we = 0; dm_size = SIZE_H; dm_addr = 32'h300;
        memBus.mem_ready = 1; memBus.mem_rdata = 32'hBAD;
        @(negedge clk);
        chk("w_idle", busy, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(); memBus.mem_ready = 0;
            @(negedge clk);
            chk("w_wait", {memBus.mem_req, memBus.mem_size, dm_ack}, 5'b1_001_0);
            chk("w_addr", memBus.mem_addr, 32'h300);
        end
        cyc(); memBus.mem_ready = 1; memBus.mem_rdata = 32'hCAFE;
        @(negedge clk);
        chk("w_sixth", {memBus.mem_req, dm_ack}, 2'b10);
        chk("w_addr6", memBus.mem_addr, 32'h300);
        cyc(); memBus.mem_ready = 0;
        @(negedge clk);
        chk("w_ack", {dm_ack, memBus.mem_req}, 2'b10);
        chk("w_rdata", dm_rdata, 32'hCAFE);
        cyc(); dm_req = 0;
        @(negedge clk);
        chk("w_hold", {dm_ack, dm_rdata}, {1'b0, 32'hCAFE});

        // Reset during the second BUSY cycle abandons the transfer.
        cyc(); dm_req = 1; dm_size = SIZE_W; dm_addr = 32'h500;
        cyc();
        @(negedge clk);
        chk("r_busy1", busy, 1);
        cyc(); reset = 1;
        @(negedge clk);
        chk("r_busy2", memBus.mem_req, 1);
        cyc(); reset = 0; dm_req = 0; memBus.mem_ready = 1; memBus.mem_rdata = 32'h777;
        @(negedge clk);
        chk("r_after", {memBus.mem_req, busy, dm_ack}, 0);
        chk("r_rdata", dm_rdata, 0);
        cyc(); memBus.mem_ready = 0;
        @(negedge clk);
        chk("r_noack", {dm_ack, if_ack, busy}, 0);
        chk("r_late", dm_rdata, 0);

        // Load, then fetch, then store.
        cyc(); dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        @(negedge clk);
        chk("l_idle", busy, 0);
        cyc(); memBus.mem_ready = 1; memBus.mem_rdata = 32'h1234;
        @(negedge clk);
        chk("l_addr", {memBus.mem_we, memBus.mem_addr}, {1'b0, 32'h40});
        cyc(); memBus.mem_ready = 0;
        @(negedge clk);
        chk("l_ack", {dm_ack, dm_rdata}, {1'b1, 32'h1234});
        cyc(); dm_req = 0; if_req = 1; if_addr = 32'h108;
        @(negedge clk);
        chk("l_hold", {busy, dm_rdata}, {1'b0, 32'h1234});
        cyc(); memBus.mem_ready = 1; memBus.mem_rdata = 32'h99;
        @(negedge clk);
        chk("l_f_addr", memBus.mem_addr, 32'h108);
        cyc(); memBus.mem_ready = 0;
        @(negedge clk);
        chk("l_f_ack", {if_ack, if_rdata}, {1'b1, 32'h99});
        chk("l_dm_keep", dm_rdata, 32'h1234);
        cyc(); if_req = 0; dm_req = 1; dm_we = 1; dm_addr = 32'h44; dm_wdata = 32'h11;
        @(negedge clk);
        chk("l_st_idle", busy, 0);
        cyc(); memBus.mem_ready = 1; memBus.mem_rdata = 32'hFFFF;
        @(negedge clk);
        chk("l_st_bus", {memBus.mem_we, memBus.mem_wdata}, {1'b1, 32'h11});
        cyc(); memBus.mem_ready = 0;
        @(negedge clk);
        chk("l_st_ack", {dm_ack, dm_rdata}, {1'b1, 32'h0});
        chk("l_if_keep", if_rdata, 32'h99);
        cyc(); dm_req = 0; dm_we = 0;

        // Starvation on the standalone selector: four data grants, then fetch.
        for (int i = 0; i < 19; i++) begin
            cyc();
            selIf = vIf[i]; selDm = vDm[i]; selEn = vEn[i]; selEx = vEx[i];
            @(negedge clk);
            chk($sformatf("sel_%0d", i), {selGif, selGdm}, {eIf[i], eDm[i]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
